// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared state encoding and sizing helpers for the bit-serial subtractor
package serial_subtractor_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: combinational one-bit difference/borrow cell
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b - bin using one full_subtractor cell and a borrow flop
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);
  localparam int CW = cnt_w(WIDTH);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, diff_q, diff_d, res;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d, bout_q, bout_d, zero_q, zero_d;
  logic             d, br_next, last, go;
  full_subtractor u_fs (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .bin (br_q),
    .d   (d),
    .bout(br_next)
  );
  assign res  = {d, r_q[WIDTH-1:1]};
  assign last = cnt_q == CW'(WIDTH - 1);
  assign go   = start && state_q != BUSY;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    if (go) begin
      state_d = BUSY;
      a_d     = a;
      b_d     = b;
      br_d    = bin;
      cnt_d   = '0;
    end else if (state_q == BUSY) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      r_d   = res;
      br_d  = br_next;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        state_d = DONE;
        diff_d  = res;
        bout_d  = br_next;
        zero_d  = res == '0;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
    end
  end
  assign busy = state_q == BUSY;
  assign done = state_q == DONE;
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor at WIDTH=4
module tb_serial_subtractor;
  typedef struct packed {
    logic [3:0] diff;
    logic       bout;
    logic       zero;
  } exp_t;
  logic       clk = 0, rst_n = 0, start = 0, bin = 0;
  logic [3:0] a = 0, b = 0;
  logic       busy, done, bout, zero;
  logic [3:0] diff;
  exp_t       sb[$];
  exp_t       e;
  int         n_tests = 0, n_fail = 0;
  serial_subtractor #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .zero(zero)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [4:0] t;
    t = {1'b0, x} - {1'b0, y} - {4'b0, c};
    return '{diff: t[3:0], bout: t[4], zero: t[3:0] == 4'd0};
  endfunction
  task automatic launch(input logic [3:0] x, input logic [3:0] y, input logic c);
    a = x; b = y; bin = c; start = 1;
    sb.push_back(model(x, y, c));
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done(output logic got, output int lat, output int bcnt);
    got = 0; lat = 0; bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        got = 1;
        break;
      end
      bcnt += busy;
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic pop_exp(output exp_t x);
    x = (sb.size() != 0) ? sb.pop_front() : '0;
  endtask
  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, done, diff, bout, zero} !== 8'b0000_0001) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b diff=%b bout=%b zero=%b want 0 0 0000 0 1", busy, done, diff, bout, zero);
    end
    rst_n = 1;
    @(negedge clk);
  endtask
  task automatic test_basic;
    logic got; int lat, bc;
    launch(4'b0101, 4'b0011, 0);
    wait_done(got, lat, bc);
    n_tests++;
    if (!got || lat !== 4) begin n_fail++; $display("FAIL basic_latency: got=%b lat=%0d want done lat 4", got, lat); end
    n_tests++;
    if (bc !== 4) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 4", bc); end
    pop_exp(e);
    n_tests++;
    if ({diff, bout, zero} !== {e.diff, e.bout, e.zero} || e.diff !== 4'b0010) begin
      n_fail++; $display("FAIL basic_result: got %b/%b/%b want %b/%b/%b", diff, bout, zero, e.diff, e.bout, e.zero);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 0 || busy !== 0) begin n_fail++; $display("FAIL basic_done_pulse: done=%b busy=%b want 0 0", done, busy); end
  endtask
  task automatic test_borrow;
    logic got; int lat, bc;
    logic [3:0] xa[2] = '{4'b0000, 4'b1111};
    logic [3:0] xb[2] = '{4'b0001, 4'b1111};
    logic       xc[2] = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      launch(xa[i], xb[i], xc[i]);
      wait_done(got, lat, bc);
      pop_exp(e);
      n_tests++;
      if (!got || {diff, bout, zero} !== {e.diff, e.bout, e.zero} || {e.diff, e.bout} !== 5'b1111_1) begin
        n_fail++; $display("FAIL borrow_%0d: got=%b %b/%b/%b want %b/%b/%b", i, got, diff, bout, zero, e.diff, e.bout, e.zero);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_zero;
    logic got = 0; int bad = 0;
    logic [3:0] prev;
    prev = diff;
    launch(4'b1010, 4'b1010, 0);
    for (int i = 0; i < 20 && !got; i++) begin
      if (done) got = 1;
      else begin
        if (busy && diff !== prev) bad++;
        @(negedge clk);
      end
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL zero_hold_during_busy: %0d changes of diff, want 0 (held %b)", bad, prev); end
    pop_exp(e);
    n_tests++;
    if (!got || {diff, bout, zero} !== {e.diff, e.bout, e.zero} || e.zero !== 1) begin
      n_fail++; $display("FAIL zero_result: got=%b %b/%b/%b want %b/%b/%b", got, diff, bout, zero, e.diff, e.bout, e.zero);
    end
    @(negedge clk);
  endtask
  task automatic test_ignore_start;
    logic got; int lat, bc, extra = 0;
    launch(4'b1000, 4'b0001, 0);
    @(negedge clk);
    a = 0; b = 0; start = 1;
    @(negedge clk);
    start = 0;
    wait_done(got, lat, bc);
    pop_exp(e);
    n_tests++;
    if (!got || diff !== e.diff || e.diff !== 4'b0111) begin
      n_fail++; $display("FAIL ignore_start_result: got=%b diff=%b want %b", got, diff, e.diff);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    n_tests++;
    if (extra != 0) begin n_fail++; $display("FAIL ignore_start_extra: %0d busy/done cycles after completion, want 0", extra); end
  endtask
  task automatic test_back_to_back;
    logic got; int lat, bc;
    launch(4'b0111, 4'b0001, 0);
    wait_done(got, lat, bc);
    pop_exp(e);
    n_tests++;
    if (!got || diff !== e.diff) begin n_fail++; $display("FAIL b2b_first: got=%b diff=%b want %b", got, diff, e.diff); end
    launch(4'b0110, 4'b0010, 0);
    n_tests++;
    if (busy !== 1) begin n_fail++; $display("FAIL b2b_accept: busy=%b want 1", busy); end
    wait_done(got, lat, bc);
    pop_exp(e);
    n_tests++;
    if (!got || lat + 1 != 5) begin n_fail++; $display("FAIL b2b_spacing: got=%b spacing=%0d want 5", got, lat + 1); end
    n_tests++;
    if (diff !== e.diff || e.diff !== 4'b0100) begin n_fail++; $display("FAIL b2b_second: diff=%b want %b", diff, e.diff); end
    @(negedge clk);
  endtask
  task automatic test_reset_mid;
    logic got; int lat, bc, seen = 0;
    launch(4'b1111, 4'b0001, 0);
    @(negedge clk);
    rst_n = 0;
    #1;
    n_tests++;
    if ({busy, done, diff, zero} !== 7'b00_0000_1) begin
      n_fail++; $display("FAIL reset_mid_state: busy=%b done=%b diff=%b zero=%b want 0 0 0000 1", busy, done, diff, zero);
    end
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL reset_mid_no_done: %0d busy/done cycles, want 0", seen); end
    launch(4'b0011, 4'b0001, 0);
    wait_done(got, lat, bc);
    pop_exp(e);
    n_tests++;
    if (!got || diff !== e.diff || e.diff !== 4'b0010) begin n_fail++; $display("FAIL reset_mid_next: got=%b diff=%b want %b", got, diff, e.diff); end
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_borrow;
    test_zero;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
